// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger: fires a trigger pulse, times the sensor echo and reports the
// distance in centimetres, or 1023 with timeout=1 when the echo never rises or never falls.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES    = 1000,
    parameter int CYCLES_PER_CM  = 5800,
    parameter int TIMEOUT_CYCLES = 3000000,
    parameter int HOLDOFF_CYCLES = 6000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_ultra,
    input  logic       echo,
    output logic       trig,
    output logic [9:0] distance_cm,
    output logic       timeout,
    output logic       ultrasonic_valid,
    output logic       busy,
    output logic [2:0] state_dbg
);

    // start_ultra is a one-cycle request taken only in IDLE (never queued);
    // ultrasonic_valid is a one-cycle strobe with no backpressure.
    localparam int MAX_TT    = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int PHASE_MAX = (MAX_TT > HOLDOFF_CYCLES) ? MAX_TT : HOLDOFF_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int SUB_W     = $clog2(CYCLES_PER_CM + 1);

    localparam logic [PHASE_W-1:0] TRIG_LAST    = PHASE_W'(TRIG_CYCLES - 1);
    localparam logic [PHASE_W-1:0] TIMEOUT_LAST = PHASE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HOLDOFF_LAST = PHASE_W'(HOLDOFF_CYCLES - 1);
    localparam logic [SUB_W-1:0]   SUB_LAST     = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [9:0]         CM_MAX       = 10'd1023;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t             state, state_next;
    logic               echo_meta, echo_s;
    logic [PHASE_W-1:0] phase_cnt, phase_next;
    logic [SUB_W-1:0]   sub_cnt, sub_next, sub_inc;
    logic [9:0]         cm_cnt, cm_next, cm_inc;
    logic               result_load, result_timeout;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // One echo-high cycle worth of counting; cm saturates rather than wrapping.
    always_comb begin
        sub_inc = sub_cnt + SUB_W'(1);
        cm_inc  = cm_cnt;
        if (sub_cnt == SUB_LAST) begin
            sub_inc = '0;
            if (cm_cnt != CM_MAX) cm_inc = cm_cnt + 10'd1;
        end
    end

    always_comb begin
        state_next     = state;
        phase_next     = phase_cnt;
        sub_next       = sub_cnt;
        cm_next        = cm_cnt;
        result_load    = 1'b0;
        result_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (start_ultra) begin
                    state_next = TRIG;
                    phase_next = '0;
                    sub_next   = '0;
                    cm_next    = '0;
                end
            end
            TRIG: begin
                if (phase_cnt == TRIG_LAST) begin
                    state_next = WAIT_RISE;
                    phase_next = '0;
                end else begin
                    phase_next = phase_cnt + PHASE_W'(1);
                end
            end
            WAIT_RISE: begin
                // The rise cycle itself is echo-high time, so it is counted here.
                if (echo_s) begin
                    state_next = MEASURE;
                    phase_next = '0;
                    sub_next   = sub_inc;
                    cm_next    = cm_inc;
                end else if (phase_cnt == TIMEOUT_LAST) begin
                    state_next     = HOLDOFF;
                    phase_next     = '0;
                    result_load    = 1'b1;
                    result_timeout = 1'b1;
                end else begin
                    phase_next = phase_cnt + PHASE_W'(1);
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_next  = HOLDOFF;
                    phase_next  = '0;
                    result_load = 1'b1;
                end else if (phase_cnt == TIMEOUT_LAST) begin
                    state_next     = HOLDOFF;
                    phase_next     = '0;
                    result_load    = 1'b1;
                    result_timeout = 1'b1;
                end else begin
                    phase_next = phase_cnt + PHASE_W'(1);
                    sub_next   = sub_inc;
                    cm_next    = cm_inc;
                end
            end
            HOLDOFF: begin
                if (phase_cnt == HOLDOFF_LAST) begin
                    state_next = IDLE;
                    phase_next = '0;
                end else begin
                    phase_next = phase_cnt + PHASE_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they change on the transition edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_cnt        <= '0;
            sub_cnt          <= '0;
            cm_cnt           <= '0;
            trig             <= 1'b0;
            busy             <= 1'b0;
            ultrasonic_valid <= 1'b0;
            distance_cm      <= '0;
            timeout          <= 1'b0;
        end else begin
            phase_cnt        <= phase_next;
            sub_cnt          <= sub_next;
            cm_cnt           <= cm_next;
            trig             <= (state_next == TRIG);
            busy             <= (state_next != IDLE);
            ultrasonic_valid <= result_load;
            if (result_load) begin
                distance_cm <= result_timeout ? CM_MAX : cm_cnt;
                timeout     <= result_timeout;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger: directed scenarios plus randomized echo pulses,
// each checked against a cycle-level model of the ranging rules.
module tb_ultrasonic_ranger;

    localparam int TRIG    = 10;
    localparam int CPC     = 5;
    localparam int TMO     = 200;
    localparam int HOLD    = 20;
    localparam int SYNC_LAT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_ultra;
    logic       echo;
    logic       trig;
    logic [9:0] distance_cm;
    logic       timeout;
    logic       ultrasonic_valid;
    logic       busy;
    logic [2:0] state_dbg;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    int         trig_hi, trig_rise, valid_n, valid_cyc, busy_fall;
    logic [9:0] got_dist;
    logic       got_to;
    logic       trig_prev = 1'b0;
    logic       busy_prev = 1'b0;

    ultrasonic_ranger #(
        .TRIG_CYCLES   (TRIG),
        .CYCLES_PER_CM (CPC),
        .TIMEOUT_CYCLES(TMO),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_ultra     (start_ultra),
        .echo            (echo),
        .trig            (trig),
        .distance_cm     (distance_cm),
        .timeout         (timeout),
        .ultrasonic_valid(ultrasonic_valid),
        .busy            (busy),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_records();
        trig_hi   = 0;
        trig_rise = -1;
        valid_n   = 0;
        valid_cyc = -1;
        busy_fall = -1;
        got_dist  = '0;
        got_to    = 1'b0;
    endtask

    // Advance to the next falling edge and log what the outputs did.
    task automatic step();
        @(negedge clk);
        if (trig) begin
            trig_hi++;
            if (!trig_prev && trig_rise < 0) trig_rise = cyc;
        end
        if (ultrasonic_valid) begin
            valid_n++;
            valid_cyc = cyc;
            got_dist  = distance_cm;
            got_to    = timeout;
        end
        if (!busy && busy_prev && busy_fall < 0) busy_fall = cyc;
        trig_prev = trig;
        busy_prev = busy;
    endtask

    // One measurement: echo driven high for len cycles starting off cycles after trig rises.
    task automatic measure(input string name, input int off, input int len, input bit spam);
        int r, f, d, rise_e, end_e, n, exp_valid, hold_rel, rel;
        logic [9:0] exp_dist;
        logic exp_to;
        clear_records();
        start_ultra = 1'b1;
        step();
        start_ultra = 1'b0;
        for (int i = 0; i < 5 && trig_rise < 0; i++) step();
        vectors++;
        if (trig_rise < 0) begin
            errors++;
            $display("FAIL %s_trig_start: got no trig rise, expected one within 5 cycles", name);
            return;
        end
        r = trig_rise;
        f = r + TRIG;
        d = r + off;
        rise_e = (d + SYNC_LAT > f + 1) ? d + SYNC_LAT : f + 1;
        end_e  = d + len + SYNC_LAT - 1;
        if (len == 0 || end_e < rise_e || rise_e > f + TMO) begin
            exp_valid = f + TMO;
            exp_dist  = 10'd1023;
            exp_to    = 1'b1;
        end else begin
            n = end_e - rise_e + 1;
            if (n > TMO) begin
                exp_valid = rise_e + TMO;
                exp_dist  = 10'd1023;
                exp_to    = 1'b1;
            end else begin
                exp_valid = rise_e + n;
                exp_dist  = (n / CPC > 1023) ? 10'd1023 : 10'(n / CPC);
                exp_to    = 1'b0;
            end
        end
        hold_rel = exp_valid - r + 5;

        for (int k = 0; k < 900 && busy_fall < 0; k++) begin
            rel = cyc - r;
            echo = (rel >= off && rel < off + len);
            start_ultra = spam && (rel == 3 || (len > 10 && rel == off + 5) || rel == hold_rel);
            step();
        end
        start_ultra = 1'b0;
        echo        = 1'b0;

        vectors++;
        if (trig_hi !== TRIG) begin
            errors++;
            $display("FAIL %s_trig_width: got %0d expected %0d", name, trig_hi, TRIG);
        end
        vectors++;
        if (valid_n !== 1) begin
            errors++;
            $display("FAIL %s_valid_count: got %0d expected 1", name, valid_n);
        end
        vectors++;
        if (valid_cyc !== exp_valid) begin
            errors++;
            $display("FAIL %s_valid_cycle: got %0d expected %0d", name, valid_cyc - r, exp_valid - r);
        end
        vectors++;
        if (got_dist !== exp_dist) begin
            errors++;
            $display("FAIL %s_distance: got %0d expected %0d", name, got_dist, exp_dist);
        end
        vectors++;
        if (got_to !== exp_to) begin
            errors++;
            $display("FAIL %s_timeout: got %0b expected %0b", name, got_to, exp_to);
        end
        vectors++;
        if (busy_fall !== exp_valid + HOLD) begin
            errors++;
            $display("FAIL %s_busy_fall: got %0d expected %0d", name, busy_fall - r, exp_valid + HOLD - r);
        end

        for (int k = 0; k < 3; k++) step();
        vectors++;
        if (busy !== 1'b0 || trig_hi !== TRIG || valid_n !== 1) begin
            errors++;
            $display("FAIL %s_no_restart: got busy=%0b trig_cycles=%0d valids=%0d expected busy=0 trig_cycles=%0d valids=1",
                     name, busy, trig_hi, valid_n, TRIG);
        end
        vectors++;
        if (distance_cm !== exp_dist || timeout !== exp_to) begin
            errors++;
            $display("FAIL %s_hold: got %0d/%0b expected %0d/%0b", name, distance_cm, timeout, exp_dist, exp_to);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        start_ultra = 1'b0;
        echo        = 1'b0;
        clear_records();
        step();
        step();
        vectors++;
        if ({trig, busy, ultrasonic_valid, timeout} !== 4'b0000 || distance_cm !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got trig=%0b busy=%0b valid=%0b timeout=%0b dist=%0d expected all 0",
                     trig, busy, ultrasonic_valid, timeout, distance_cm);
        end
        reset = 1'b1;
        step();
        step();
    endtask

    task automatic test_basic();
        measure("basic", TRIG + 2, 50, 1'b0);
    endtask

    task automatic test_no_echo();
        measure("no_echo", 0, 0, 1'b0);
    endtask

    task automatic test_stuck_echo();
        measure("stuck_echo", TRIG + 2, 400, 1'b0);
    endtask

    task automatic test_boundary();
        measure("len_at_timeout", TRIG + 2, TMO, 1'b0);
        measure("len_past_timeout", TRIG + 2, TMO + 1, 1'b0);
        measure("len_one", TRIG + 2, 1, 1'b0);
    endtask

    task automatic test_start_ignored();
        measure("start_ignored", TRIG + 2, 30, 1'b1);
    endtask

    task automatic test_early_echo();
        measure("early_echo", 5, 20, 1'b0);
    endtask

    task automatic test_idle_echo();
        clear_records();
        echo = 1'b1;
        for (int k = 0; k < 6; k++) step();
        echo = 1'b0;
        for (int k = 0; k < 6; k++) step();
        vectors++;
        if (busy !== 1'b0 || valid_n !== 0 || trig_hi !== 0) begin
            errors++;
            $display("FAIL idle_echo_ignored: got busy=%0b valids=%0d trig_cycles=%0d expected 0/0/0",
                     busy, valid_n, trig_hi);
        end
        measure("idle_echo", TRIG + 2, 4, 1'b0);
    endtask

    task automatic test_reset_abort();
        int r;
        clear_records();
        start_ultra = 1'b1;
        step();
        start_ultra = 1'b0;
        for (int i = 0; i < 5 && trig_rise < 0; i++) step();
        r = trig_rise;
        for (int k = 0; k < 40 && r >= 0; k++) begin
            echo = (cyc - r >= 12);
            step();
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({trig, busy, ultrasonic_valid, timeout} !== 4'b0000 || distance_cm !== 10'd0) begin
            errors++;
            $display("FAIL reset_abort_outputs: got trig=%0b busy=%0b valid=%0b timeout=%0b dist=%0d expected all 0",
                     trig, busy, ultrasonic_valid, timeout, distance_cm);
        end
        echo = 1'b0;
        for (int k = 0; k < 4; k++) step();
        vectors++;
        if (valid_n !== 0) begin
            errors++;
            $display("FAIL reset_abort_no_valid: got %0d valids expected 0", valid_n);
        end
        reset = 1'b1;
        step();
        step();
        measure("reset_recover", TRIG + 2, 25, 1'b0);
    endtask

    task automatic test_random();
        int off, len;
        bit spam;
        for (int i = 0; i < 12; i++) begin
            off  = $urandom_range(0, 60);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(190, 260) : $urandom_range(0, 120);
            spam = 1'($urandom_range(0, 1));
            measure($sformatf("rand%0d", i), off, len, spam);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_echo();
        test_stuck_echo();
        test_boundary();
        test_start_ignored();
        test_early_echo();
        test_idle_echo();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
